param_stack: RTL and testbench

Parametrised LIFO stack that generalises the 3-bit, depth-8 stack used by the Eight-Queen backtracking datapath. Width and depth are configurable. Adds full/empty/count status, overflow/underflow error pulses, a combinational top-of-stack peek, a defined simultaneous push+pop (swap) operation, and a synchronous flush. It sits between the controller FSM and the column/row registers of the search datapath.

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_op_dec.sv | 36 +++
 rtl/param_stack.sv | 108 ++++++++++
 tb/tb_param_stack.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types for the parametrised LIFO stack: operation encoding and count-width helper.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_BYPASS,
        OP_FLUSH
    } stack_op_t;

    // Bits needed to hold 0..depth; never less than one bit.
    function automatic int unsigned count_width(input int unsigned depth);
        if (depth < 2)
            count_width = 1;
        else
            count_width = $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_op_dec.sv
// Decodes push/pop/flush against the current stack status into one operation plus reject flags.
module stack_op_dec
    import stack_pkg::*;
(
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  logic      empty,
    input  logic      full,
    output stack_op_t op,
    output logic      ovf,
    output logic      unf
);

    always_comb begin
        op  = OP_IDLE;
        ovf = 1'b0;
        unf = 1'b0;
        if (flush) begin
            op = OP_FLUSH;
        end else if (push && pop) begin
            op = empty ? OP_BYPASS : OP_SWAP;
        end else if (push) begin
            if (full)
                ovf = 1'b1;
            else
                op = OP_PUSH;
        end else if (pop) begin
            if (empty)
                unf = 1'b1;
            else
                op = OP_POP;
        end
    end

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with status, error pulses, swap/bypass and flush.
// Optional PARAM_STACK_HIGH_WATER_EN adds a high_water output (max count since reset).
module param_stack
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
`ifdef PARAM_STACK_HIGH_WATER_EN
    ,
    output logic [CW-1:0]    high_water
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    stack_op_t        op;
    logic             ovf;
    logic             unf;

    // Indices are only used when the decoder has already ruled out empty/full.
    assign top_idx = AW'(count - CW'(1));
    assign wr_idx  = AW'(count);
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign top     = empty ? '0 : mem[top_idx];

    stack_op_dec u_dec (
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .empty (empty),
        .full  (full),
        .op    (op),
        .ovf   (ovf),
        .unf   (unf)
    );

    always_ff @(posedge clk) begin
        if (a_rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            mem        <= '{default: '0};
        end else begin
            dout_valid <= 1'b0;
            overflow   <= ovf;
            underflow  <= unf;
            case (op)
                OP_FLUSH: begin
                    count <= '0;
                end
                OP_PUSH: begin
                    mem[wr_idx] <= din;
                    count       <= count + CW'(1);
                end
                OP_POP: begin
                    dout       <= mem[top_idx];
                    count      <= count - CW'(1);
                    dout_valid <= 1'b1;
                end
                OP_SWAP: begin
                    dout         <= mem[top_idx];
                    mem[top_idx] <= din;
                    dout_valid   <= 1'b1;
                end
                OP_BYPASS: begin
                    dout       <= din;
                    dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PARAM_STACK_HIGH_WATER_EN
    // Tracks the registered count, so it trails a rising count by one cycle; flush does not clear it.
    always_ff @(posedge clk) begin
        if (a_rst)
            high_water <= '0;
        else if (count > high_water)
            high_water <= count;
    end
`else
    // High-water tracking not built.
`endif

endmodule

// File: tb/tb_param_stack.sv
// Randomised scoreboard bench for param_stack against a queue-based LIFO model, plus a 16x3 instance.
module tb_param_stack;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, push, pop, flush;
    logic [2:0] din;
    logic [2:0] dout, top;
    logic [3:0] count;
    logic       dout_valid, empty, full, overflow, underflow;
`ifdef PARAM_STACK_HIGH_WATER_EN
    logic [3:0] high_water;
    logic [1:0] s_high_water;
`endif

    logic        s_rst, s_push, s_pop, s_flush;
    logic [15:0] s_din, s_dout, s_top;
    logic [1:0]  s_count;
    logic        s_dout_valid, s_empty, s_full, s_overflow, s_underflow;

    param_stack #(.WIDTH(3), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .a_rst      (a_rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .top        (top),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
`ifdef PARAM_STACK_HIGH_WATER_EN
        ,
        .high_water (high_water)
`endif
    );

    param_stack #(.WIDTH(16), .DEPTH(3)) u_small (
        .clk        (clk),
        .a_rst      (s_rst),
        .push       (s_push),
        .pop        (s_pop),
        .flush      (s_flush),
        .din        (s_din),
        .dout       (s_dout),
        .dout_valid (s_dout_valid),
        .top        (s_top),
        .count      (s_count),
        .empty      (s_empty),
        .full       (s_full),
        .overflow   (s_overflow),
        .underflow  (s_underflow)
`ifdef PARAM_STACK_HIGH_WATER_EN
        ,
        .high_water (s_high_water)
`endif
    );

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Reference model: a plain queue whose back is the top of stack.
    logic [2:0]  stk[$];
    logic [2:0]  exp_q[$];
    logic [2:0]  m_dout;
    bit          m_valid, m_ovf, m_unf;
    int unsigned m_hw;
    logic [2:0]  mon_exp;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Data checker: every dout_valid pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #2;
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("dout_valid_unexpected", 32'(dout_valid), 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("scoreboard_dout", 32'(dout), 32'(mon_exp));
            end
        end
    end

    task automatic do_op(input bit r, input bit p, input bit o, input bit f, input logic [2:0] d);
        a_rst = r; push = p; pop = o; flush = f; din = d;
        m_valid = 0; m_ovf = 0; m_unf = 0;
        if (r)
            m_hw = 0;
        else if (stk.size() > m_hw)
            m_hw = stk.size();
        if (r) begin
            stk.delete();
            m_dout = '0;
        end else if (f) begin
            stk.delete();
        end else if (p && o) begin
            if (stk.size() == 0) begin
                m_dout = d;
            end else begin
                m_dout = stk[stk.size() - 1];
                stk[stk.size() - 1] = d;
            end
            m_valid = 1;
        end else if (p) begin
            if (stk.size() == DEPTH) m_ovf = 1;
            else stk.push_back(d);
        end else if (o) begin
            if (stk.size() == 0) begin
                m_unf = 1;
            end else begin
                m_dout  = stk.pop_back();
                m_valid = 1;
            end
        end
        if (m_valid) exp_q.push_back(m_dout);
        @(posedge clk);
        #1;
        chk("count", 32'(count), stk.size());
        chk("top", 32'(top), (stk.size() != 0) ? 32'(stk[stk.size() - 1]) : 0);
        chk("empty", 32'(empty), (stk.size() == 0) ? 1 : 0);
        chk("full", 32'(full), (stk.size() == DEPTH) ? 1 : 0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("dout", 32'(dout), 32'(m_dout));
`ifdef PARAM_STACK_HIGH_WATER_EN
        chk("high_water", 32'(high_water), m_hw);
`endif
        @(negedge clk);
    endtask

    task automatic s_op(input bit r, input bit p, input bit o, input logic [15:0] d,
                        input int unsigned e_count, input int unsigned e_top,
                        input int unsigned e_dv, input int unsigned e_dout,
                        input int unsigned e_full, input int unsigned e_ovf);
        s_rst = r; s_push = p; s_pop = o; s_flush = 1'b0; s_din = d;
        @(posedge clk);
        #1;
        chk("s_count", 32'(s_count), e_count);
        chk("s_top", 32'(s_top), e_top);
        chk("s_dout_valid", 32'(s_dout_valid), e_dv);
        chk("s_dout", 32'(s_dout), e_dout);
        chk("s_full", 32'(s_full), e_full);
        chk("s_overflow", 32'(s_overflow), e_ovf);
        @(negedge clk);
    endtask

    initial begin
        a_rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0;
        s_rst = 1'b1; s_push = 1'b0; s_pop = 1'b0; s_flush = 1'b0; s_din = '0;
        m_dout = '0; m_hw = 0;
        @(negedge clk);

        // 16-bit, depth-3 instance (main stack held in reset meanwhile).
        s_op(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0);
        s_op(0, 1, 0, 16'hFFFF, 1, 16'hFFFF, 0, 16'h0000, 0, 0);
        s_op(0, 1, 0, 16'h1234, 2, 16'h1234, 0, 16'h0000, 0, 0);
        s_op(0, 1, 0, 16'h0001, 3, 16'h0001, 0, 16'h0000, 1, 0);
        s_op(0, 1, 1, 16'hABCD, 3, 16'hABCD, 1, 16'h0001, 1, 0);
        s_op(0, 1, 0, 16'h5555, 3, 16'hABCD, 0, 16'h0001, 1, 1);
        s_op(0, 0, 1, 16'h0000, 2, 16'h1234, 1, 16'hABCD, 0, 0);

        do_op(1, 0, 0, 0, 3'd0);
        // Push 1,2,3 then pop three times.
        do_op(0, 1, 0, 0, 3'd1);
        do_op(0, 1, 0, 0, 3'd2);
        do_op(0, 1, 0, 0, 3'd3);
        repeat (3) do_op(0, 0, 1, 0, 3'd0);
        // Fill, reject a ninth push of 7, pop the eighth value.
        for (int i = 0; i < 8; i++) do_op(0, 1, 0, 0, 3'((i % 7) + 1));
        do_op(0, 1, 0, 0, 3'd7);
        do_op(0, 0, 1, 0, 3'd0);
        do_op(0, 0, 0, 1, 3'd0);
        // Underflow, then bypass.
        do_op(0, 0, 1, 0, 3'd0);
        do_op(0, 1, 1, 0, 3'd5);
        // Swap in the middle and at full.
        do_op(0, 1, 0, 0, 3'd4);
        do_op(0, 1, 0, 0, 3'd6);
        do_op(0, 1, 1, 0, 3'd2);
        for (int i = 0; i < 6; i++) do_op(0, 1, 0, 0, 3'(i));
        do_op(0, 1, 1, 0, 3'd7);
        do_op(0, 1, 1, 0, 3'd3);
        // Flush with push, then reset during a pop.
        do_op(0, 0, 0, 1, 3'd0);
        for (int i = 0; i < 5; i++) do_op(0, 1, 0, 0, 3'(i + 2));
        do_op(0, 1, 0, 1, 3'd1);
        do_op(0, 1, 0, 0, 3'd4);
        do_op(0, 1, 0, 0, 3'd5);
        do_op(1, 0, 1, 0, 3'd0);

        for (int i = 0; i < 800; i++) begin
            do_op(($urandom_range(0, 199) == 0),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 39) == 0),
                  3'($urandom));
        end

        do_op(0, 0, 0, 0, 3'd0);
        do_op(0, 0, 0, 0, 3'd0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
